sync_fifo_16_loc: RTL and testbench



---
 rtl/sync_fifo_16_loc.sv | 93 +++++++++
 tb/tb_sync_fifo_16_loc.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_16_loc.sv
// sync_fifo_16_loc: single-clock FIFO with 2**ADDR_WIDTH entries (16 by default).
// Storage is a register array addressed by binary pointers that carry one extra
// wrap bit. The full and empty flags come straight from the registered pointers,
// and read data is registered with a one-cycle latency.
// Optional feature: define FIFO_ERR_FLAGS_EN to add the sticky overflow and
// underflow outputs.
module sync_fifo_16_loc #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // The pointers match exactly when the FIFO is empty. They differ only in the
    // wrap bit when it is full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    // A write to a full FIFO and a read from an empty FIFO are both ignored.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // Storage array: written only when a write is accepted.
    // NOTE: the memory has no reset. The pointers alone decide which entries are
    // valid, so clearing the array would add reset fan-out and gain nothing.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Write pointer: advances once per accepted write and wraps modulo 2**(ADDR_WIDTH+1).
    // NOTE: all sequential state uses non-blocking assignments, so every register
    // samples values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
        end else if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Read pointer and registered read data. rd_data holds its value when no read is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            rd_data <= '0;
        end else if (rd_accept) begin
            rd_ptr  <= rd_ptr + PTR_ONE;
            rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags: set by any request the FIFO had to reject, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_16_loc.sv
// tb_sync_fifo_16_loc: self-checking bench for sync_fifo_16_loc.
// A queue-based reference model tracks the expected contents, read data and flags.
// Directed steps come first, followed by randomized traffic.
module tb_sync_fifo_16_loc;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd_data;
    logic          m_ovf;
    logic          m_udf;

    sync_fifo_16_loc #(.DATA_WIDTH(DW), .ADDR_WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " empty"},   {31'd0, empty}, {31'd0, q.size() == 0});
        check({tag, " full"},    {31'd0, full},  {31'd0, q.size() == DEPTH});
        check({tag, " rd_data"}, rd_data,        m_rd_data);
`ifdef FIFO_ERR_FLAGS_EN
        check({tag, " overflow"},  {31'd0, overflow},  {31'd0, m_ovf});
        check({tag, " underflow"}, {31'd0, underflow}, {31'd0, m_udf});
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_rd_data = '0;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
    endtask

    // Present one request, let one rising edge pass, update the model, then check on the falling edge.
    task automatic step(input string tag, input logic we, input logic [DW-1:0] wd, input logic re);
        bit wr_ok;
        bit rd_ok;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        wr_ok = we && (q.size() < DEPTH);
        rd_ok = re && (q.size() > 0);
        if (we && q.size() == DEPTH) m_ovf = 1'b1;
        if (re && q.size() == 0)     m_udf = 1'b1;
        if (rd_ok) m_rd_data = q.pop_front();
        if (wr_ok) q.push_back(wd);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        model_reset();

        // Reset held for 100 ns.
        #100;
        check_outputs("in_reset");
        @(negedge clk);
        rst = 1'b1;
        step("idle", 1'b0, 32'h0, 1'b0);
        step("idle2", 1'b0, 32'h0, 1'b0);

        // Single write, then single read.
        step("wr_11", 1'b1, 32'h11, 1'b0);
        step("rd_11", 1'b0, 32'h0, 1'b1);
        check("rd_11 const", rd_data, 32'h11);

        // Fill to 15, then to full, then attempt one dropped write.
        for (int i = 0; i < 15; i++) step("fill", 1'b1, DW'(i), 1'b0);
        step("wr_ff", 1'b1, 32'hff, 1'b0);
        check("full_const", {31'd0, full}, 32'd1);
        step("wr_drop", 1'b1, 32'h99, 1'b0);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 32'h0, 1'b1);
        check("drain_last", rd_data, 32'hff);

        // Read from an empty FIFO: rd_data holds its value.
        step("rd_empty", 1'b0, 32'h0, 1'b1);
        check("rd_empty_hold", rd_data, 32'hff);

        // Pointer wrap past 16.
        step("w55", 1'b1, 32'h55, 1'b0);
        step("wee", 1'b1, 32'hee, 1'b0);
        step("waa", 1'b1, 32'haa, 1'b0);
        step("r55", 1'b0, 32'h0, 1'b1);
        step("ree", 1'b0, 32'h0, 1'b1);
        step("w11", 1'b1, 32'h11, 1'b0);
        step("raa", 1'b0, 32'h0, 1'b1);
        step("r11", 1'b0, 32'h0, 1'b1);
        check("wrap_r11", rd_data, 32'h11);

        // Simultaneous write and read while holding 8 entries.
        for (int i = 0; i < 8; i++) step("fill8", 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 12; i++) step("simul", 1'b1, $urandom, 1'b1);
        check("simul_occ", q.size(), 32'd8);

        // Simultaneous write and read on an empty FIFO: only the write is accepted.
        for (int i = 0; i < 8; i++) step("drain8", 1'b0, 32'h0, 1'b1);
        step("simul_empty", 1'b1, 32'h1234, 1'b1);
        // Simultaneous write and read on a full FIFO: only the read is accepted.
        for (int i = 0; i < 15; i++) step("fill_full", 1'b1, $urandom, 1'b0);
        step("simul_full", 1'b1, 32'hdead, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 50));
        end

        // Asynchronous reset mid-stream takes effect before the next rising edge.
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, $urandom, 1'b0);
        step("pre_rst_rd", 1'b0, 32'h0, 1'b1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst_idle", 1'b0, 32'h0, 1'b0);
        step("post_rst_rd", 1'b0, 32'h0, 1'b1);

        // More randomized traffic after reset.
        for (int i = 0; i < 200; i++) begin
            step("rand2", ($urandom_range(0, 99) < 50), $urandom, ($urandom_range(0, 99) < 50));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
